// File: rtl/program_counter.sv
// Program counter with load, increment and a two-state RUN/HALTED FSM.
// Define PROGRAM_COUNTER_OVF_EN to add the sticky OVF wrap flag output.
module program_counter #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [WIDTH-1:0] D,
  input  logic             LOAD,
  input  logic             INC,
  input  logic             HALT,
`ifdef PROGRAM_COUNTER_OVF_EN
  output logic             OVF,
`endif
  output logic [WIDTH-1:0] Q,
  output logic             HALTED
);

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_next_s;

  // Next-state and next-count selection in LOAD > HALT > INC > hold order.
  always_comb begin
    q_next_s     = q_r;
    state_next_s = state_r;
    if (LOAD) begin
      q_next_s     = D;
      state_next_s = ST_RUN;
    end else if (state_r == ST_RUN) begin
      if (HALT) begin
        state_next_s = ST_HALTED;
      end else if (INC) begin
        q_next_s = q_r + {{(WIDTH-1){1'b0}}, 1'b1};
      end else begin
        q_next_s = q_r;
      end
    end else begin
      // Halted: only LOAD or reset can leave this state.
      state_next_s = ST_HALTED;
    end
  end

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_r <= ST_RUN;
      q_r     <= RESET_VAL;
    end else begin
      state_r <= state_next_s;
      q_r     <= q_next_s;
    end
  end

  assign Q      = q_r;
  assign HALTED = (state_r == ST_HALTED);

`ifdef PROGRAM_COUNTER_OVF_EN
  logic ovf_r;
  logic wrap_s;

  // A wrap happens only on an honoured increment from all-ones.
  assign wrap_s = !LOAD && (state_r == ST_RUN) && !HALT && INC && (&q_r);

  // Sticky wrap flag, cleared by reset or LOAD.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      ovf_r <= 1'b0;
    end else if (LOAD) begin
      ovf_r <= 1'b0;
    end else if (wrap_s) begin
      ovf_r <= 1'b1;
    end else begin
      ovf_r <= ovf_r;
    end
  end

  assign OVF = ovf_r;
`endif

endmodule

// File: tb/tb_program_counter.sv
// Scoreboard bench for program_counter: a 16-bit instance for the main
// sequence and a 4-bit instance (RESET_VAL=4'hE) for the narrow wrap case.
module tb_program_counter;

  typedef struct {
    logic [15:0] q;
    logic        h;
    logic        o;
    logic        chk4;
    logic [3:0]  q4;
    logic        o4;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic [15:0] D;
  logic        LOAD, INC, HALT;
  logic [15:0] Q;
  logic        HALTED;
  logic        inc4;
  logic [3:0]  q4;
  logic        halted4;
  logic [3:0]  d4;
  logic        zero;
  logic        ovf;
  logic        ovf4;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  program_counter #(.WIDTH(16), .RESET_VAL(16'h0000)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .D(D), .LOAD(LOAD), .INC(INC), .HALT(HALT),
`ifdef PROGRAM_COUNTER_OVF_EN
    .OVF(ovf),
`endif
    .Q(Q), .HALTED(HALTED)
  );

  program_counter #(.WIDTH(4), .RESET_VAL(4'hE)) dut4 (
    .CLK(CLK), .RESET_N(RESET_N), .D(d4), .LOAD(zero), .INC(inc4), .HALT(zero),
`ifdef PROGRAM_COUNTER_OVF_EN
    .OVF(ovf4),
`endif
    .Q(q4), .HALTED(halted4)
  );

`ifndef PROGRAM_COUNTER_OVF_EN
  assign ovf  = 1'b0;
  assign ovf4 = 1'b0;
`endif

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: compare DUT outputs against the oldest expectation, away from the rising edge.
  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("q", Q, e.q);
      chk("halted", {15'h0000, HALTED}, {15'h0000, e.h});
`ifdef PROGRAM_COUNTER_OVF_EN
      chk("ovf", {15'h0000, ovf}, {15'h0000, e.o});
`endif
      if (e.chk4) begin
        chk("q4", {12'h000, q4}, {12'h000, e.q4});
        chk("halted4", {15'h0000, halted4}, 16'h0000);
`ifdef PROGRAM_COUNTER_OVF_EN
        chk("ovf4", {15'h0000, ovf4}, {15'h0000, e.o4});
`endif
      end
    end
  end

  task automatic step(input logic rst_n, input logic load, input logic [15:0] d,
                      input logic inc, input logic halt, input logic i4,
                      input logic [15:0] eq, input logic eh, input logic eo,
                      input logic c4, input logic [3:0] eq4, input logic eo4);
    exp_t e;
    RESET_N = rst_n; LOAD = load; D = d; INC = inc; HALT = halt; inc4 = i4;
    @(posedge CLK);
    e.q = eq; e.h = eh; e.o = eo; e.chk4 = c4; e.q4 = eq4; e.o4 = eo4;
    exp_q.push_back(e);
    @(negedge CLK);
  endtask

  initial begin
    RESET_N = 1'b0; D = 16'h0000; LOAD = 1'b0; INC = 1'b0; HALT = 1'b0;
    inc4 = 1'b0; d4 = 4'h0; zero = 1'b0;
    @(negedge CLK);
    // Reset then five increments; narrow instance goes E,F,0,1 and holds.
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 4'hE, 1'b0);
    step(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b1, 4'hF, 1'b0);
    step(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0002, 1'b0, 1'b0, 1'b1, 4'h0, 1'b1);
    step(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0003, 1'b0, 1'b0, 1'b1, 4'h1, 1'b1);
    step(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0004, 1'b0, 1'b0, 1'b1, 4'h1, 1'b1);
    step(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0005, 1'b0, 1'b0, 1'b1, 4'h1, 1'b1);
    // LOAD wins over a simultaneous INC.
    step(1'b1, 1'b1, 16'h1234, 1'b1, 1'b0, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    step(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h1235, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    // HALT wins over INC at Q=7; INC and HALT ignored while halted.
    step(1'b1, 1'b1, 16'h0007, 1'b0, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    step(1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0007, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
    for (int i = 0; i < 10; i++)
      step(1'b1, 1'b0, 16'h0000, 1'b1, (i == 3) ? 1'b1 : 1'b0, 1'b0, 16'h0007, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
    step(1'b1, 1'b1, 16'h0040, 1'b0, 1'b0, 1'b0, 16'h0040, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0040, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0040, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    // Wrap from all-ones; OVF sticks through further increments until LOAD.
    step(1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    step(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
    step(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
    step(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
    step(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
    step(1'b1, 1'b1, 16'h0005, 1'b0, 1'b0, 1'b0, 16'h0005, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    // A reset glitch between edges must not disturb state.
    #2 RESET_N = 1'b0;
    #2 RESET_N = 1'b1;
    step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0005, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    // Wrap again so reset has a set OVF to clear, then halt.
    step(1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    step(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
    step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
    // Reset with LOAD while halted; first INC afterwards is honoured.
    step(1'b0, 1'b1, 16'hAAAA, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    step(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    RESET_N = 1'b1; LOAD = 1'b0; INC = 1'b0; HALT = 1'b0;
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge CLK);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/program_counter.md
PROGRAM_COUNTER -- requirements
Module: program_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, which is the counter width in bits (minimum 2).
REQ-002 The block SHALL have parameter RESET_VAL, default 0, which is the Q value loaded on reset (WIDTH bits).
REQ-003 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port RESET_N, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port Q, output, WIDTH bits: the current counter value, registered.
REQ-006 The block SHALL have port D, input, WIDTH bits: the value to load.
REQ-007 The block SHALL have port LOAD, input, 1 bit: load D into Q.
REQ-008 The block SHALL have port INC, input, 1 bit: increment Q.
REQ-009 The block SHALL have port HALT, input, 1 bit: request entry to the halted state.
REQ-010 The block SHALL have port HALTED, output, 1 bit: high while the FSM is in HALTED; registered.
REQ-011 The block SHALL have port OVF, output, 1 bit: sticky wrap flag; present only per REQ-029.

Function
REQ-012 The block SHALL update Q, FSM state, HALTED and OVF only on the rising edge of CLK, with no combinational input-to-output path.
REQ-013 The FSM SHALL have exactly two states: RUN (encoding 0) and HALTED (encoding 1); the HALTED output SHALL equal the state bit.
REQ-014 Per-edge priority SHALL be: RESET_N low > LOAD > HALT > INC > hold.
REQ-015 LOAD high with RESET_N high SHALL set Q <= D and state <= RUN in either state, and SHALL ignore HALT and INC in that cycle.
REQ-016 In RUN, HALT high with LOAD low SHALL set state <= HALTED with Q held; a simultaneous INC SHALL be ignored.
REQ-017 In RUN, INC high with LOAD and HALT low SHALL set Q <= (Q + 1) mod 2^WIDTH.
REQ-018 Wrap-around: Q at all-ones with INC applied SHALL become all-zeros the next cycle; no saturation.
REQ-019 In HALTED, INC and HALT SHALL have no effect; Q and state SHALL hold until LOAD or reset.
REQ-020 With all control inputs low, Q and state SHALL hold indefinitely.
REQ-021 Latency SHALL be exactly one cycle from a qualifying input edge to the visible change on Q or HALTED.

Reset
REQ-022 RESET_N low at a rising CLK edge SHALL set Q <= RESET_VAL, state <= RUN, HALTED <= 0 and OVF <= 0.
REQ-023 Reset SHALL override LOAD, HALT and INC asserted in the same cycle.
REQ-024 A RESET_N pulse that does not span a rising CLK edge SHALL have no effect.
REQ-025 Reset asserted while in HALTED SHALL return the FSM to RUN, with the first INC after release honoured.
REQ-026 Outputs SHALL be undefined only before the first reset edge; no initial-value reliance is permitted.

Configuration
REQ-027 The compile-time macro PROGRAM_COUNTER_OVF_EN SHALL control the wrap flag feature.
REQ-028 Without PROGRAM_COUNTER_OVF_EN, the OVF port and its register SHALL be absent and wrap-around SHALL be silent.
REQ-029 With PROGRAM_COUNTER_OVF_EN, the OVF port SHALL exist and SHALL be set on the edge where REQ-018 wraps Q.
REQ-030 With PROGRAM_COUNTER_OVF_EN, OVF SHALL remain set until reset or LOAD clears it; a LOAD and a wrap never coincide, per REQ-014.
REQ-031 With PROGRAM_COUNTER_OVF_EN, the Q, HALTED and priority behaviour SHALL be identical to the behaviour without the macro.

Verification
REQ-032 The bench SHALL cover reset then 5 cycles of INC=1 -> Q sequence 0,1,2,3,4,5; HALTED=0.
REQ-033 The bench SHALL cover LOAD=1 with D=16'h1234 and INC=1 in the same cycle -> Q=16'h1234 next cycle, then INC -> 16'h1235.
REQ-034 The bench SHALL cover HALT=1 with INC=1 at Q=7 -> HALTED=1 and Q=7, held for 10 cycles of INC=1; then LOAD D=16'h0040 -> Q=16'h0040 and HALTED=0.
REQ-035 The bench SHALL cover LOAD D=16'hFFFF, then INC -> Q=16'h0000; with the macro, OVF=1 and stays set through 3 more INCs, and LOAD clears it to 0.
REQ-036 The bench SHALL cover RESET_N=0 together with LOAD=1, D=16'hAAAA, while in HALTED -> Q=RESET_VAL, HALTED=0, OVF=0.
REQ-037 The bench SHALL cover WIDTH=4, RESET_VAL=4'hE with 3 INCs after reset -> Q sequence E,F,0,1.
